// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-port (I fetch / D load) arbiter for a single-port combinational instruction ROM
module rom_arbiter #(
    parameter logic [31:0] BASE_ADDR  = 32'hBFC00000,
    parameter logic [31:0] ROM_BYTES  = 32'h00008000,
    parameter int unsigned MAX_STARVE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        rom_en,
    output logic [3:0]  rom_write_en,
    output logic [31:0] rom_addr,
    output logic [31:0] rom_write_data,
    input  logic [31:0] rom_read_data
);

    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    // Encoding chosen so the registered state reads directly as {i_rvalid, d_rvalid}
    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_D    = 2'b01,
        SRC_I    = 2'b10
    } src_e;

    src_e        src_q, src_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_err_q, i_err_d;
    logic        d_err_q, d_err_d;

    logic        starve_full;
    logic [31:0] gnt_addr;
    logic [31:0] gnt_off;
    logic        addr_err;
    logic [31:0] resp_word;

    always_comb begin
        starve_full = (starve_q == STARVE_MAX);
        i_gnt       = i_req & (~d_req | starve_full);
        d_gnt       = d_req & ~i_gnt;
        gnt_addr    = i_gnt ? i_addr : (d_gnt ? d_addr : 32'd0);
        // Wrap-around subtraction folds addresses below the base into huge offsets
        gnt_off     = gnt_addr - BASE_ADDR;
        addr_err    = (gnt_addr[1:0] != 2'b00) | (gnt_off > (ROM_BYTES - 32'd4));
        resp_word   = addr_err ? 32'd0 : rom_read_data;
    end

    assign rom_en         = (i_gnt | d_gnt) & ~addr_err;
    assign rom_addr       = gnt_addr;
    assign rom_write_en   = 4'b0000;
    assign rom_write_data = 32'd0;

    always_comb begin
        src_d     = SRC_NONE;
        i_rdata_d = i_rdata_q;
        i_err_d   = i_err_q;
        d_rdata_d = d_rdata_q;
        d_err_d   = d_err_q;
        if (i_gnt) begin
            src_d     = SRC_I;
            i_rdata_d = resp_word;
            i_err_d   = addr_err;
        end else if (d_gnt) begin
            src_d     = SRC_D;
            d_rdata_d = resp_word;
            d_err_d   = addr_err;
        end
    end

    always_comb begin
        starve_d = 4'd0;
        if (i_req && !i_gnt) begin
            starve_d = starve_full ? STARVE_MAX : starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q     <= SRC_NONE;
            starve_q  <= 4'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
        end else begin
            src_q     <= src_d;
            starve_q  <= starve_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_err_q   <= i_err_d;
            d_err_q   <= d_err_d;
        end
    end

    assign i_rvalid = (src_q == SRC_I);
    assign d_rvalid = (src_q == SRC_D);
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    // Error flags are only meaningful alongside rvalid but hold like rdata
    assign i_err    = i_err_q;
    assign d_err    = d_err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - self-checking bench for rom_arbiter with table vectors, corner sequences and random traffic
module tb_rom_arbiter;

    localparam logic [31:0] BASE       = 32'hBFC00000;
    localparam logic [31:0] ROM_BYTES  = 32'h00008000;
    localparam int          MAX_STARVE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr;
    logic        i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, rom_en;
    logic [31:0] i_rdata, d_rdata, rom_addr, rom_write_data, rom_read_data;
    logic [3:0]  rom_write_en;

    logic [31:0] mem [0:8191];

    int errors = 0;
    int checks = 0;

    // Reference state: pending response per port and I's denied-cycle count
    int          m_starve;
    bit          m_iv, m_dv, m_ie, m_de;
    logic [31:0] m_ird, m_drd;
    bit          last_gi, last_gd;

    always #5 clk = ~clk;

    assign rom_read_data = rom_en ? mem[rom_addr[14:2]] : 32'hDEADBEEF;

    rom_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .rom_en(rom_en), .rom_write_en(rom_write_en), .rom_addr(rom_addr),
        .rom_write_data(rom_write_data), .rom_read_data(rom_read_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_starve = 0;
        m_iv = 0; m_dv = 0; m_ie = 0; m_de = 0;
        m_ird = 0; m_drd = 0;
        last_gi = 0; last_gd = 0;
    endtask

    // Called just after a rising edge with inputs already applied; returns just after the next edge
    task automatic run_cycle();
        bit          gi, gd, e;
        logic [31:0] a, off, w;
        #1;
        gi  = i_req && (!d_req || m_starve == MAX_STARVE);
        gd  = d_req && !gi;
        a   = gi ? i_addr : (gd ? d_addr : 32'd0);
        off = a - BASE;
        e   = (a % 4 != 0) || (off > ROM_BYTES - 4);
        w   = 32'd0;
        if (!e) w = mem[off / 4];
        chk("i_gnt", i_gnt, gi);
        chk("d_gnt", d_gnt, gd);
        chk("rom_en", rom_en, (gi || gd) && !e);
        chk("rom_addr", rom_addr, a);
        chk("rom_write_en", rom_write_en, 0);
        chk("rom_write_data", rom_write_data, 0);
        if (i_req && !gi) m_starve = (m_starve < MAX_STARVE) ? m_starve + 1 : MAX_STARVE;
        else              m_starve = 0;
        last_gi = gi; last_gd = gd;
        @(posedge clk); #1;
        m_iv = gi; m_dv = gd;
        if (gi) begin m_ie = e; m_ird = w; end
        if (gd) begin m_de = e; m_drd = w; end
        chk("i_rvalid", i_rvalid, m_iv);
        chk("d_rvalid", d_rvalid, m_dv);
        chk("i_err", i_err, m_ie);
        chk("d_err", d_err, m_de);
        chk("i_rdata", i_rdata, m_ird);
        chk("d_rdata", d_rdata, m_drd);
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 9))
            0:       return $urandom;
            1:       return BASE + $urandom_range(0, 32767);
            2:       return BASE + ROM_BYTES + ($urandom & 32'hFC);
            3:       return BASE - 32'd4 * $urandom_range(1, 64);
            default: return BASE + ($urandom_range(0, 8191) << 2);
        endcase
    endfunction

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic [31:0] da;
        logic        eig;
        logic        edg;
        logic        een;
        logic [31:0] era;
        logic        eerr;
        logic [31:0] edat;
    } vec_t;

    vec_t vt [9];
    bit   exp_d_win [5];

    initial begin
        for (int k = 0; k < 8192; k++) mem[k] = $urandom;
        mem[0]    = 32'h3C1DA000;
        mem[1]    = 32'h24020001;
        mem[2]    = 32'h8C430000;
        mem[4]    = 32'hCAFE0010;
        mem[8]    = 32'h0BADF00D;
        mem[8191] = 32'h1234ABCD;

        //          ir  ia            dr  da            ig  dg  en  rom_addr      err data
        vt[0] = '{1'b1, 32'hBFC00004, 1'b0, 32'h0,        1, 0, 1, 32'hBFC00004, 0, 32'h24020001};
        vt[1] = '{1'b0, 32'h0,        1'b1, 32'hBFC00002, 0, 1, 0, 32'hBFC00002, 1, 32'h0};
        vt[2] = '{1'b1, 32'hBFC08000, 1'b0, 32'h0,        1, 0, 0, 32'hBFC08000, 1, 32'h0};
        vt[3] = '{1'b1, 32'hBFBFFFFC, 1'b0, 32'h0,        1, 0, 0, 32'hBFBFFFFC, 1, 32'h0};
        vt[4] = '{1'b1, 32'hBFC07FFC, 1'b0, 32'h0,        1, 0, 1, 32'hBFC07FFC, 0, 32'h1234ABCD};
        vt[5] = '{1'b0, 32'h0,        1'b0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0};
        vt[6] = '{1'b1, 32'hBFC00020, 1'b1, 32'hBFC00010, 0, 1, 1, 32'hBFC00010, 0, 32'hCAFE0010};
        vt[7] = '{1'b1, 32'hBFC00020, 1'b0, 32'h0,        1, 0, 1, 32'hBFC00020, 0, 32'h0BADF00D};
        vt[8] = '{1'b0, 32'h0,        1'b0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0};

        exp_d_win = '{1, 1, 1, 0, 1};

        rst = 1'b0; i_req = 0; d_req = 0; i_addr = 0; d_addr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset i_rvalid", i_rvalid, 0);
        chk("reset d_rvalid", d_rvalid, 0);
        chk("reset i_rdata", i_rdata, 0);
        chk("reset d_rdata", d_rdata, 0);
        chk("reset i_err", i_err, 0);
        chk("reset d_err", d_err, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            i_req = vt[v].ir; i_addr = vt[v].ia;
            d_req = vt[v].dr; d_addr = vt[v].da;
            #1;
            chk("vec i_gnt", i_gnt, vt[v].eig);
            chk("vec d_gnt", d_gnt, vt[v].edg);
            chk("vec rom_en", rom_en, vt[v].een);
            chk("vec rom_addr", rom_addr, vt[v].era);
            run_cycle();
            chk("vec i_rvalid", i_rvalid, vt[v].eig);
            chk("vec d_rvalid", d_rvalid, vt[v].edg);
            if (vt[v].eig) begin
                chk("vec i_err", i_err, vt[v].eerr);
                chk("vec i_rdata", i_rdata, vt[v].edat);
            end
            if (vt[v].edg) begin
                chk("vec d_err", d_err, vt[v].eerr);
                chk("vec d_rdata", d_rdata, vt[v].edat);
            end
        end

        // Contention: D wins three times, then the starved I port gets one slot
        i_req = 1; i_addr = 32'hBFC00100;
        d_req = 1; d_addr = 32'hBFC00200;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("contend d_gnt", d_gnt, exp_d_win[c]);
            chk("contend i_gnt", i_gnt, !exp_d_win[c]);
            run_cycle();
            if (exp_d_win[c]) d_addr = d_addr + 4;
            else              i_addr = i_addr + 4;
        end
        i_req = 0; d_req = 0;
        run_cycle();

        // Back-to-back D reads
        d_req = 1; d_addr = 32'hBFC00000;
        run_cycle();
        chk("b2b first d_rvalid", d_rvalid, 1);
        chk("b2b first d_rdata", d_rdata, 32'h3C1DA000);
        d_addr = 32'hBFC00008;
        run_cycle();
        chk("b2b second d_rvalid", d_rvalid, 1);
        chk("b2b second d_rdata", d_rdata, 32'h8C430000);
        d_req = 0;
        run_cycle();

        // Reset while a D response is being presented
        d_req = 1; d_addr = 32'hBFC00040;
        run_cycle();
        chk("pre-reset d_rvalid", d_rvalid, 1);
        #2;
        rst = 1'b0; d_req = 0;
        #1;
        chk("async reset d_rvalid", d_rvalid, 0);
        chk("async reset d_rdata", d_rdata, 0);
        chk("async reset d_err", d_err, 0);
        chk("async reset i_rvalid", i_rvalid, 0);
        chk("async reset i_rdata", i_rdata, 0);
        chk("async reset gnt", {i_gnt, d_gnt, rom_en}, 0);
        chk("async reset rom_addr", rom_addr, 0);
        model_reset();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        repeat (3) run_cycle();

        // Random traffic; an ungranted request keeps its address
        for (int n = 0; n < 400; n++) begin
            if (!(i_req && !last_gi)) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = rnd_addr();
            end
            if (!(d_req && !last_gd)) begin
                d_req  = ($urandom_range(0, 2) != 0);
                d_addr = rnd_addr();
            end
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single-port, combinational-read instruction ROM between two requesters: instruction fetch (I port) and data load (D port).
- Grants one requester per cycle, drives the ROM address and enable, and registers the read word.
- Returns the word to the winner one cycle later with a valid pulse.
- D has priority; a saturating starvation counter guarantees I forward progress. Misaligned and out-of-range addresses return an error response without touching the ROM.

Parameters:
- BASE_ADDR, 32'hBFC00000, byte address mapped to ROM offset 0 (reset PC).
- ROM_BYTES, 32'h00008000, ROM size in bytes. Valid offsets are 0..ROM_BYTES-4.
- MAX_STARVE, 3, consecutive denied I cycles after which I wins the next contended cycle. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  instruction read request
- i_addr  in  32  instruction byte address
- i_gnt  out  1  I request accepted this cycle (combinational)
- i_rvalid  out  1  I response valid (one-cycle pulse)
- i_rdata  out  32  I read word
- i_err  out  1  I response error, qualified by i_rvalid
- d_req  in  1  data read request
- d_addr  in  32  data byte address
- d_gnt  out  1  D request accepted this cycle (combinational)
- d_rvalid  out  1  D response valid
- d_rdata  out  32  D read word
- d_err  out  1  D response error, qualified by d_rvalid
- rom_en  out  1  ROM read enable
- rom_write_en  out  4  ROM byte write enables, constant 0
- rom_addr  out  32  ROM byte address, equal to the granted requester's address
- rom_write_data  out  32  constant 0
- rom_read_data  in  32  ROM word, combinational from rom_addr/rom_en

Behaviour:
- Reset (rst=0, asynchronous):
  - starve_cnt=0; resp_src=NONE.
  - i_rvalid, d_rvalid, i_err, d_err = 0; i_rdata, d_rdata = 0.
  - A response in flight at reset assertion is discarded and never delivered.
- Arbitration (combinational):
  - Only I requesting: i_gnt=1.
  - Only D requesting: d_gnt=1.
  - Both requesting: D wins unless starve_cnt==MAX_STARVE, in which case I wins.
  - i_gnt and d_gnt are never both 1. No request means no grant.
- Handshake:
  - A requester holds req and addr stable until it sees gnt.
  - req may stay high after gnt to issue a new request, giving back-to-back one-per-cycle throughput.
  - Requests cannot be retracted while ungranted; the bench must not do this.
- Address check on the granted address:
  - off = addr - BASE_ADDR, 32-bit wrap-around subtraction.
  - Error if addr[1:0]!=0 or off > ROM_BYTES-4 (unsigned compare).
- ROM drive:
  - rom_en = 1 only for a granted, non-error request.
  - rom_addr = granted addr when a grant exists, else 0.
  - rom_write_en = 0 and rom_write_data = 0 always.
- Response register (one cycle latency):
  - On the clk edge after a grant, the winner's rvalid=1 for exactly one cycle.
  - rdata = rom_read_data sampled at that edge, or 0 if error; err = error flag.
  - The loser's rvalid stays 0; with no grant both rvalids are 0 next cycle.
  - Non-granted port's rdata and err hold their last values.
- Starvation counter (4-bit):
  - Next value = MAX_STARVE if (i_req & !i_gnt & starve_cnt==MAX_STARVE).
  - Next value = starve_cnt+1 if (i_req & !i_gnt) below that.
  - Next value = 0 if i_gnt or !i_req.
  - Saturates; never wraps.
- State machine resp_src ∈ {NONE, I, D}:
  - Next state = I on i_gnt, D on d_gnt, NONE otherwise.
  - It selects which rvalid/rdata/err are updated.
  - Its registered value equals {i_rvalid, d_rvalid}.

Test Plan:
- Reset:
  - Stimulus: assert rst=0 mid-cycle while d_rvalid is pending.
  - Required: all outputs 0 immediately; after release with no requests, no rvalid ever appears.
- I only:
  - Stimulus: i_req=1, i_addr=32'hBFC00004, ROM word 0x24020001.
  - Required: i_gnt=1 the same cycle, rom_addr=32'hBFC00004, rom_en=1; next cycle i_rvalid=1, i_rdata=0x24020001, i_err=0.
- Contention, MAX_STARVE=3:
  - Stimulus: i_req and d_req held high for 5 cycles.
  - Required: d_gnt in cycles 0-2, i_gnt in cycle 3, d_gnt in cycle 4. starve_cnt runs 0,1,2,3,0.
- Back-to-back D:
  - Stimulus: d_addr 32'hBFC00000 then 32'hBFC00008 on consecutive cycles.
  - Required: d_rvalid high for 2 consecutive cycles with the matching words in order.
- Misaligned:
  - Stimulus: d_addr=32'hBFC00002.
  - Required: d_gnt=1, rom_en=0; next cycle d_rvalid=1, d_err=1, d_rdata=0.
- Out of range:
  - Stimulus: i_addr=32'hBFC08000.
  - Required: i_err=1.
  - Stimulus: i_addr=32'hBFBFFFFC (wraps to a large offset).
  - Required: i_err=1.
  - Stimulus: i_addr=32'hBFC07FFC.
  - Required: i_err=0 with valid data.
